name_column_sequencer: RTL and testbench

- Sequences the 5-bit column input of the `name` letter-display block; col_data connects directly to `name.a`.
- Holds a small writable message buffer of letter codes and expands each letter through a 5x5 glyph ROM.
- Emits 5 glyph columns per letter plus blank gap columns, each column held for a programmable number of clocks.
- Offers a start/stop/busy/done handshake with optional looping.

---
 rtl/name_pkg.sv | 12 +
 rtl/name_glyph_rom.sv | 29 ++
 rtl/name_column_sequencer.sv | 119 +++++++++++
 tb/tb_name_column_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/name_pkg.sv
// name_pkg: shared letter codes, sequencer states and glyph geometry for the name display
package name_pkg;
    localparam int COLS_PER_CHAR = 5;
    localparam logic [4:0] CODE_A = 5'd0, CODE_B = 5'd1, CODE_C = 5'd2, CODE_D = 5'd3,
                           CODE_E = 5'd4, CODE_F = 5'd5, CODE_G = 5'd6, CODE_H = 5'd7,
                           CODE_I = 5'd8, CODE_J = 5'd9, CODE_K = 5'd10, CODE_L = 5'd11,
                           CODE_M = 5'd12, CODE_N = 5'd13, CODE_O = 5'd14, CODE_P = 5'd15,
                           CODE_Q = 5'd16, CODE_R = 5'd17, CODE_S = 5'd18, CODE_T = 5'd19,
                           CODE_U = 5'd20, CODE_V = 5'd21, CODE_W = 5'd22, CODE_X = 5'd23,
                           CODE_Y = 5'd24, CODE_Z = 5'd25, CODE_BLANK = 5'd31;
    typedef enum logic [1:0] {IDLE, GLYPH, GAP} state_t;
endpackage

// File: rtl/name_glyph_rom.sv
// name_glyph_rom: 5x5 column patterns per letter code; unknown letters and blank are dark
module name_glyph_rom
    import name_pkg::*;
(
    input  logic [4:0] code,
    input  logic [2:0] col,
    output logic [4:0] pattern
);
    logic [24:0] g;
    always_comb begin
        g = '0;
        case (code)
            CODE_M: g = {5'h1F, 5'h18, 5'h04, 5'h18, 5'h1F};
            CODE_E: g = {5'h1F, 5'h15, 5'h15, 5'h11, 5'h11};
            CODE_N: g = {5'h1F, 5'h10, 5'h1F, 5'h01, 5'h1F};
            CODE_A: g = {5'h1F, 5'h14, 5'h14, 5'h14, 5'h1F};
            CODE_K: g = {5'h1F, 5'h04, 5'h04, 5'h0A, 5'h11};
            CODE_S: g = {5'h1D, 5'h15, 5'h15, 5'h15, 5'h17};
            CODE_H: g = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h1F};
            CODE_I: g = {5'h11, 5'h11, 5'h1F, 5'h11, 5'h11};
            default: g = '0;
        endcase
    end
    assign pattern = col == 3'd0 ? g[24:20] :
                     col == 3'd1 ? g[19:15] :
                     col == 3'd2 ? g[14:10] :
                     col == 3'd3 ? g[9:5]   :
                     col == 3'd4 ? g[4:0]   : 5'h00;
endmodule

// File: rtl/name_column_sequencer.sv
// name_column_sequencer: walks a writable letter buffer through the glyph ROM, one held column at a time
module name_column_sequencer
    import name_pkg::*;
#(
    parameter int MAX_CHARS = 9,
    parameter int TICK_DIV  = 5,
    parameter int GAP_COLS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    input  logic [3:0] msg_len,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [4:0] wr_code,
    output logic [4:0] col_data,
    output logic       col_valid,
    output logic [3:0] char_idx,
    output logic       busy,
    output logic       done
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [3:0] MAXC = 4'(MAX_CHARS);
    localparam logic [2:0] LAST_COL = 3'(COLS_PER_CHAR - 1);
    localparam logic [2:0] LAST_GAP = 3'(GAP_COLS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TICK_DIV - 1);

    state_t state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [2:0] col, col_n;
    logic [3:0] len, len_n, idx_n;
    logic [4:0] code, code_n, rom_out;
    logic done_n, glyph_end, gap_end;
    logic [4:0] msg_buf [16];

    assign glyph_end = state == GLYPH && col == LAST_COL;
    assign gap_end = state == GAP && col == LAST_GAP;

    always_comb begin
        state_n = state;
        tick_n = tick;
        col_n = col;
        len_n = len;
        idx_n = char_idx;
        code_n = code;
        done_n = 1'b0;
        if (state == IDLE) begin
            if (start && !stop && msg_len != 4'd0) begin
                state_n = GLYPH;
                tick_n = '0;
                col_n = '0;
                idx_n = '0;
                len_n = msg_len > MAXC ? MAXC : msg_len;
                code_n = msg_buf[0];
            end
        end else if (stop) begin
            state_n = IDLE;
            tick_n = '0;
            col_n = '0;
            idx_n = '0;
        end else if (tick != LAST_TICK) begin
            tick_n = tick + TW'(1);
        end else begin
            tick_n = '0;
            col_n = col + 3'd1;
            if (gap_end || (glyph_end && GAP_COLS == 0)) begin
                state_n = GLYPH;
                col_n = '0;
                // the code is latched only as a letter begins, so buffer writes never tear a glyph
                if (char_idx != len - 4'd1) begin
                    idx_n = char_idx + 4'd1;
                    code_n = msg_buf[idx_n];
                end else if (loop_en) begin
                    idx_n = '0;
                    code_n = msg_buf[0];
                end else begin
                    state_n = IDLE;
                    idx_n = '0;
                    done_n = 1'b1;
                end
            end else if (glyph_end) begin
                state_n = GAP;
                col_n = '0;
            end
        end
    end

    name_glyph_rom u_rom (.code(code_n), .col(col_n), .pattern(rom_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tick <= '0;
            col <= '0;
            len <= '0;
            code <= CODE_BLANK;
            char_idx <= '0;
            col_data <= '0;
            col_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            for (int i = 0; i < 16; i++) msg_buf[i] <= CODE_BLANK;
        end else begin
            state <= state_n;
            tick <= tick_n;
            col <= col_n;
            len <= len_n;
            code <= code_n;
            char_idx <= idx_n;
            col_data <= state_n == GLYPH ? rom_out : 5'h00;
            col_valid <= state_n != IDLE;
            busy <= state_n != IDLE;
            done <= done_n;
            if (wr_en && wr_addr < MAXC) msg_buf[wr_addr] <= wr_code;
        end
    end
endmodule

// File: tb/tb_name_column_sequencer.sv
// tb_name_column_sequencer: directed frames with hand-written glyph columns for the sequencer
module tb_name_column_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
    logic [3:0] msg_len = '0, wr_addr = '0;
    logic [4:0] wr_code = '0;
    logic [4:0] col_data;
    logic col_valid, busy, done;
    logic [3:0] char_idx;
    int checks = 0, failures = 0;
    logic [4:0] word [9] = '{5'd12, 5'd4, 5'd4, 5'd13, 5'd0, 5'd10, 5'd18, 5'd7, 5'd8};

    name_column_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .msg_len(msg_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
        .col_data(col_data), .col_valid(col_valid), .char_idx(char_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [4:0] c);
        wr_en = 1'b1;
        wr_addr = a;
        wr_code = c;
        step();
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [3:0] n);
        msg_len = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [4:0] glyph(input logic [4:0] code, input int c);
        logic [4:0] t [5];
        case (code)
            5'd12: t = '{5'h1F, 5'h18, 5'h04, 5'h18, 5'h1F};
            5'd4:  t = '{5'h1F, 5'h15, 5'h15, 5'h11, 5'h11};
            5'd13: t = '{5'h1F, 5'h10, 5'h1F, 5'h01, 5'h1F};
            5'd0:  t = '{5'h1F, 5'h14, 5'h14, 5'h14, 5'h1F};
            5'd10: t = '{5'h1F, 5'h04, 5'h04, 5'h0A, 5'h11};
            5'd18: t = '{5'h1D, 5'h15, 5'h15, 5'h15, 5'h17};
            5'd7:  t = '{5'h1F, 5'h04, 5'h04, 5'h04, 5'h1F};
            5'd8:  t = '{5'h11, 5'h11, 5'h1F, 5'h11, 5'h11};
            default: t = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
        endcase
        return c < 5 ? t[c] : 5'h00;
    endfunction

    initial begin
        int cnt;
        #3;
        chk("rst_col_data", 32'(col_data), 32'h0);
        chk("rst_col_valid", 32'(col_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 9; i++) wr(4'(i), word[i]);

        // full MEENAKSHI frame
        go(4'd9);
        chk("t1_busy", 32'(busy), 32'h1);
        for (int n = 0; n < 270; n++) begin
            chk($sformatf("t1_col%0d", n), 32'(col_data), 32'(glyph(word[n / 30], (n % 30) / 5)));
            chk($sformatf("t1_valid%0d", n), 32'(col_valid), 32'h1);
            if (n % 30 == 0) chk($sformatf("t1_idx%0d", n), 32'(char_idx), 32'(n / 30));
            if (done) chk($sformatf("t1_early_done%0d", n), 32'(done), 32'h0);
            step();
        end
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_busy_end", 32'(busy), 32'h0);
        chk("t1_valid_end", 32'(col_valid), 32'h0);
        chk("t1_col_end", 32'(col_data), 32'h0);
        step();
        chk("t1_done_pulse", 32'(done), 32'h0);

        // zero length ignored, oversized length clamps
        go(4'd0);
        step();
        chk("t2_len0_busy", 32'(busy), 32'h0);
        chk("t2_len0_valid", 32'(col_valid), 32'h0);
        go(4'd15);
        cnt = 0;
        while (col_valid && cnt < 400) begin
            cnt++;
            step();
        end
        chk("t2_len15_cycles", 32'(cnt), 32'd270);
        chk("t2_len15_done", 32'(done), 32'h1);
        step();

        // looping over HI
        wr(4'd0, 5'd7);
        wr(4'd1, 5'd8);
        loop_en = 1'b1;
        go(4'd2);
        for (int n = 0; n < 120; n++) begin
            if (n == 70) loop_en = 1'b0;
            if (n == 59) chk("t3_idx59", 32'(char_idx), 32'h1);
            if (n == 60) begin
                chk("t3_idx60", 32'(char_idx), 32'h0);
                chk("t3_col60", 32'(col_data), 32'h1F);
            end
            if (done || !busy) chk($sformatf("t3_run%0d", n), {done, busy}, 32'h1);
            step();
        end
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_busy", 32'(busy), 32'h0);
        step();

        // stop at cycle 37, then restart
        go(4'd2);
        for (int n = 0; n < 37; n++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_col", 32'(col_data), 32'h0);
        chk("t4_valid", 32'(col_valid), 32'h0);
        chk("t4_done", 32'(done), 32'h0);
        go(4'd2);
        chk("t4_restart_idx", 32'(char_idx), 32'h0);
        chk("t4_restart_col", 32'(col_data), 32'h1F);
        for (int n = 0; n < 5; n++) step();
        chk("t4_restart_col1", 32'(col_data), 32'h04);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // rewrite the letter on display
        loop_en = 1'b1;
        go(4'd2);
        for (int n = 0; n < 111; n++) begin
            wr_en = n == 32;
            wr_addr = 4'd1;
            wr_code = 5'd10;
            if (n == 35) chk("t5_old_c1", 32'(col_data), 32'h11);
            if (n == 40) chk("t5_old_c2", 32'(col_data), 32'h1F);
            if (n >= 90 && n % 5 == 0) chk($sformatf("t5_new%0d", n), 32'(col_data), 32'(glyph(5'd10, (n - 90) / 5)));
            step();
        end
        wr_en = 1'b0;
        loop_en = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        wr(4'd12, 5'd10);
        go(4'd9);
        for (int n = 0; n < 135; n++) step();
        chk("t5_addr12_ignored", 32'(col_data), 32'h14);

        // async reset mid-frame re-blanks the buffer
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_col", 32'(col_data), 32'h0);
        chk("t6_rst_valid", 32'(col_valid), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_idx", 32'(char_idx), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        go(4'd9);
        cnt = 0;
        for (int n = 0; n < 270; n++) begin
            if (col_valid) cnt++;
            if (col_data != 5'h0) chk($sformatf("t6_blank%0d", n), 32'(col_data), 32'h0);
            step();
        end
        chk("t6_valid_cycles", 32'(cnt), 32'd270);
        chk("t6_done", 32'(done), 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
